// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB requester and its wait timer.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ACCESS  = 2'd2,
      CAPTURE = 2'd3
   } apb_state_e;

   localparam int  DEFAULT_TIMEOUT = 16;
   localparam logic RSP_OK  = 1'b0;
   localparam logic RSP_ERR = 1'b1;

   // Wait-counter width able to hold the timeout value; never narrower than 1 bit.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait counter: cleared on request, counts enabled cycles and flags
// the cycle on which the count would reach the limit (limit 0 = never expires).
module apb_wait_timer #(
   parameter int W = 4
) (
   input  logic         PCLK,
   input  logic         PRESETn,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] count;

   always_ff @(posedge PCLK) begin
      if (!PRESETn)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && (count != '1))
         count <= count + W'(1);
   end

   assign expired = enable && (limit != '0) &&
                    (({1'b0, count} + {{W{1'b0}}, 1'b1}) >= {1'b0, limit});

endmodule

// File: rtl/apb_master.sv
// APB requester: turns single-word commands into APB transfers with a bounded
// PREADY wait and returns a one-cycle response pulse.
//
//  state   | meaning
//  IDLE    | bus idle, command port ready
//  SETUP   | PSELx up, address phase
//  ACCESS  | PENABLE up, waiting on PREADY or timeout
//  CAPTURE | bus released, PRDATA sampled at end of cycle
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDRESSWIDTH = 4,
   parameter int DATAWIDTH    = 8,
   parameter int TIMEOUT      = DEFAULT_TIMEOUT,
   parameter int RDATA_DELAY  = 1
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDRESSWIDTH-1:0] cmd_addr,
   input  logic [DATAWIDTH-1:0]    cmd_wdata,
   output logic                    rsp_valid,
   output logic [DATAWIDTH-1:0]    rsp_rdata,
   output logic                    rsp_error,
   output logic [ADDRESSWIDTH-1:0] PADDR,
   output logic [DATAWIDTH-1:0]    PWDATA,
   output logic                    PWRITE,
   output logic                    PSELx,
   output logic                    PENABLE,
   input  logic [DATAWIDTH-1:0]    PRDATA,
   input  logic                    PREADY
);

   localparam int CNT_W = cnt_width(TIMEOUT);

   apb_state_e           state, state_nxt;
   logic                 accept;
   logic                 timer_clear, timer_en, timer_exp;
   logic                 rsp_set, rsp_err_set;
   logic [DATAWIDTH-1:0] rsp_rdata_nxt;

   apb_wait_timer #(.W(CNT_W)) u_wait_timer (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .clear   (timer_clear),
      .enable  (timer_en),
      .limit   (CNT_W'(TIMEOUT)),
      .expired (timer_exp)
   );

   always_ff @(posedge PCLK) begin
      if (!PRESETn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Bus request fields are held from accept until the next accept.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         PADDR  <= '0;
         PWDATA <= '0;
         PWRITE <= 1'b0;
      end else if (accept) begin
         PADDR  <= cmd_addr;
         PWDATA <= cmd_wdata;
         PWRITE <= cmd_write;
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         rsp_valid <= 1'b0;
         rsp_error <= RSP_OK;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= rsp_set;
         rsp_error <= rsp_err_set;
         rsp_rdata <= rsp_rdata_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cmd_ready     = 1'b0;
      PSELx         = 1'b0;
      PENABLE       = 1'b0;
      accept        = 1'b0;
      timer_clear   = 1'b0;
      timer_en      = 1'b0;
      rsp_set       = 1'b0;
      rsp_err_set   = RSP_OK;
      rsp_rdata_nxt = '0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            accept    = cmd_valid;
            if (cmd_valid)
               state_nxt = SETUP;
         end
         SETUP: begin
            PSELx       = 1'b1;
            timer_clear = 1'b1;
            state_nxt   = ACCESS;
         end
         ACCESS: begin
            PSELx    = 1'b1;
            PENABLE  = 1'b1;
            timer_en = !PREADY;
            // PREADY takes priority over a timeout landing on the same edge.
            if (PREADY) begin
               if (!PWRITE && (RDATA_DELAY != 0)) begin
                  state_nxt = CAPTURE;
               end else begin
                  state_nxt = IDLE;
                  rsp_set   = 1'b1;
                  if (!PWRITE)
                     rsp_rdata_nxt = PRDATA;
               end
            end else if (timer_exp) begin
               state_nxt   = IDLE;
               rsp_set     = 1'b1;
               rsp_err_set = RSP_ERR;
            end
         end
         CAPTURE: begin
            state_nxt     = IDLE;
            rsp_set       = 1'b1;
            rsp_rdata_nxt = PRDATA;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_apb_master.sv
// Randomized scoreboard bench for apb_master with an APB slave model driving
// PREADY wait states and delayed PRDATA.
module tb_apb_master;

   localparam int TO = 6;

   logic       PCLK, PRESETn;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid, rsp_error;
   logic [7:0] rsp_rdata;
   logic [3:0] PADDR;
   logic [7:0] PWDATA, PRDATA;
   logic       PWRITE, PSELx, PENABLE, PREADY;

   apb_master #(.ADDRESSWIDTH(4), .DATAWIDTH(8), .TIMEOUT(TO), .RDATA_DELAY(1)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSELx(PSELx),
      .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   typedef struct {
      logic       err;
      logic [3:0] addr;
      logic [7:0] rdata;
      int         cyc;
   } exp_t;

   typedef struct {
      int         waits;
      logic       wr;
      logic [3:0] addr;
      logic [7:0] wdata;
   } slv_t;

   exp_t       exp_q[$];
   slv_t       slv_q[$];
   logic [7:0] ref_mem[16];
   logic [7:0] slv_mem[16];
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc   = 0;

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // Slave model: PREADY low for 'waits' ACCESS cycles, PRDATA valid one cycle after completion.
   initial begin
      int   acc_cnt;
      bit   have, done, hold_rd;
      slv_t cur;
      acc_cnt = 0; have = 0; done = 0; hold_rd = 0;
      cur = '{0, 1'b0, 4'd0, 8'd0};
      PREADY = 1'b0;
      PRDATA = 8'd0;
      forever begin
         @(negedge PCLK);
         done = 0;
         if (hold_rd) hold_rd = 0;
         else PRDATA = 8'($urandom);
         if (PSELx && !PENABLE) begin
            if (slv_q.size() == 0) begin
               fail_now("unexpected_setup");
               have = 0;
            end else begin
               cur = slv_q.pop_front();
               have = 1;
               acc_cnt = 0;
               chk("setup_paddr", 32'(PADDR), 32'(cur.addr));
               chk("setup_pwrite", 32'(PWRITE), 32'(cur.wr));
               if (cur.wr) chk("setup_pwdata", 32'(PWDATA), 32'(cur.wdata));
            end
            PREADY = 1'($urandom);
         end else if (PSELx && PENABLE && have) begin
            chk("access_paddr", 32'(PADDR), 32'(cur.addr));
            chk("access_pwrite", 32'(PWRITE), 32'(cur.wr));
            if (cur.wr) chk("access_pwdata", 32'(PWDATA), 32'(cur.wdata));
            if (acc_cnt == cur.waits) begin
               PREADY = 1'b1;
               done = 1;
               have = 0;
            end else begin
               PREADY = 1'b0;
            end
            acc_cnt++;
         end else begin
            have = 0;
            PREADY = 1'($urandom);
         end
         @(posedge PCLK);
         #1;
         if (done) begin
            if (cur.wr) slv_mem[cur.addr] = cur.wdata;
            else begin
               PRDATA = slv_mem[cur.addr];
               hold_rd = 1;
            end
         end
      end
   end

   // Response monitor: pops the scoreboard whenever the DUT presents rsp_valid.
   initial begin
      exp_t e;
      forever begin
         @(negedge PCLK);
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_rsp_valid");
            end else begin
               e = exp_q.pop_front();
               chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
               chk("rsp_error", 32'(rsp_error), 32'(e.err));
               chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
               chk("psel_in_rsp", 32'(PSELx), 32'd0);
               chk("paddr_held", 32'(PADDR), 32'(e.addr));
            end
         end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            fail_now("missing_rsp");
            void'(exp_q.pop_front());
         end
      end
   end

   // Issue one command; the reference outcome is derived from the wait count alone.
   task automatic issue(input logic wr, input logic [3:0] a, input logic [7:0] d,
                        input int waits, input bit keep, input bit want_rsp, output int acc_cyc);
      exp_t e;
      slv_t s;
      bit   ok;
      ok = 0;
      acc_cyc = -1;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge PCLK);
         if (cmd_ready) ok = 1;
      end
      if (!ok) begin
         fail_now("accept_timeout");
         cmd_valid = 1'b0;
         return;
      end
      acc_cyc = cyc;
      e.err   = (waits >= TO);
      e.addr  = a;
      e.rdata = (!wr && !e.err) ? ref_mem[a] : 8'd0;
      if (e.err)   e.cyc = cyc + 2 + TO;
      else if (wr) e.cyc = cyc + 3 + waits;
      else         e.cyc = cyc + 4 + waits;
      if (wr && !e.err) ref_mem[a] = d;
      s = '{waits, wr, a, d};
      slv_q.push_back(s);
      if (want_rsp) exp_q.push_back(e);
      @(posedge PCLK);
      #1;
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge PCLK);
      if (exp_q.size() > 0) fail_now("drain_timeout");
      @(posedge PCLK);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, a2, w;
      logic wr;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = 8'(i * 29 + 7);
         slv_mem[i] = 8'(i * 29 + 7);
      end
      PRESETn = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'd0; cmd_wdata = 8'd0;
      repeat (3) @(posedge PCLK);
      #1;
      chk("rst_psel", 32'(PSELx), 32'd0);
      chk("rst_penable", 32'(PENABLE), 32'd0);
      chk("rst_paddr", 32'(PADDR), 32'd0);
      chk("rst_pwdata", 32'(PWDATA), 32'd0);
      chk("rst_pwrite", 32'(PWRITE), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_error", 32'(rsp_error), 32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      PRESETn = 1'b1;
      @(posedge PCLK);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

      // Directed: zero-wait write, delayed-capture read, waits below and at timeout.
      issue(1'b1, 4'd2, 8'hA5, 0, 0, 1, a0);
      drain();
      issue(1'b1, 4'd3, 8'h3C, 0, 0, 1, a0);
      drain();
      issue(1'b0, 4'd3, 8'h00, 0, 0, 1, a0);
      drain();
      issue(1'b0, 4'd3, 8'h00, 5, 0, 1, a0);
      drain();
      issue(1'b0, 4'd5, 8'h00, 100, 0, 1, a0);
      drain();
      issue(1'b1, 4'd7, 8'h11, TO, 0, 1, a0);
      drain();

      // Back-to-back writes with cmd_valid held high.
      issue(1'b1, 4'd2, 8'h21, 0, 1, 1, a0);
      issue(1'b1, 4'd4, 8'h42, 0, 1, 1, a1);
      issue(1'b1, 4'd6, 8'h63, 0, 0, 1, a2);
      chk("b2b_period_1", 32'(a1 - a0), 32'd3);
      chk("b2b_period_2", 32'(a2 - a1), 32'd3);
      drain();

      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: w = $urandom_range(0, 3);
            6, 7:             w = $urandom_range(4, TO - 1);
            default:          w = $urandom_range(TO, TO + 4);
         endcase
         wr = 1'($urandom);
         issue(wr, 4'($urandom), 8'($urandom), w, bit'($urandom_range(0, 1)), 1, a0);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge PCLK);
            #1;
         end
      end
      cmd_valid = 1'b0;
      drain();

      // Reset in the middle of an ACCESS phase: bus drops, no response.
      issue(1'b0, 4'd9, 8'h00, 100, 0, 0, a0);
      for (int i = 0; i < 20 && !PENABLE; i++) @(negedge PCLK);
      chk("reached_access", 32'(PENABLE), 32'd1);
      @(negedge PCLK);
      PRESETn = 1'b0;
      @(posedge PCLK);
      #1;
      chk("midrst_psel", 32'(PSELx), 32'd0);
      chk("midrst_penable", 32'(PENABLE), 32'd0);
      chk("midrst_paddr", 32'(PADDR), 32'd0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      repeat (8) begin
         @(negedge PCLK);
         chk("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
         chk("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      @(posedge PCLK);
      #1;
      issue(1'b0, 4'd2, 8'h00, 1, 0, 1, a0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
